// File: rtl/isochronous_ce_spill_register_pkg.sv
// rtl/isochronous_ce_spill_register_pkg.sv - shared constants and helpers for the clock-enable spill register
package isochronous_ce_spill_register_pkg;

    // Two-entry FIFO addressed by 2-bit pointers; the extra bit tells full from empty.
    localparam int unsigned PtrW = 2;

    // Pointers differing only in the wrap bit mean both entries are occupied.
    localparam logic [PtrW-1:0] PtrFullXor = 2'b10;

    // Width of the phase counter; at least one bit so declarations stay legal.
    function automatic int unsigned cnt_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/isochronous_ce_spill_register_ce_gen.sv
// rtl/isochronous_ce_spill_register_ce_gen.sv - slow-domain clock-enable strobe generator
module isochronous_ce_gen
    import isochronous_ce_spill_register_pkg::*;
#(
    parameter int unsigned Ratio = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic slow_en_o
);

    if (Ratio == 1) begin : g_tied
        // Slow side runs every cycle, so there is no phase to track.
        logic unused_inputs;
        assign unused_inputs = ^{clk_i, rst_ni, sync_i};
        assign slow_en_o     = 1'b1;
    end else begin : g_cnt
        localparam int unsigned       CntW   = cnt_width(Ratio);
        localparam logic [CntW-1:0]   CntMax = CntW'(Ratio - 1);

        logic [CntW-1:0] cnt_q;
        logic [CntW-1:0] cnt_d;

        // Next phase: restart on sync, wrap at the end of the slow period.
        always_comb begin
            cnt_d = cnt_q + CntW'(1);
            if (sync_i || (cnt_q == CntMax)) begin
                cnt_d = '0;
            end
        end

        // Phase counter register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign slow_en_o = (cnt_q == CntMax);
    end

endmodule

// File: rtl/isochronous_ce_spill_register.sv
// rtl/isochronous_ce_spill_register.sv - 2-entry spill register bridging a full-rate and a clock-enabled side
module isochronous_ce_spill_register
    import isochronous_ce_spill_register_pkg::*;
#(
    parameter type         T       = logic,
    parameter int unsigned Ratio   = 2,
    parameter bit          SrcSlow = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic slow_en_o,
    input  logic src_valid_i,
    output logic src_ready_o,
    input  T     src_data_i,
    output logic dst_valid_o,
    input  logic dst_ready_i,
    output T     dst_data_o
);

    logic            slow_en;
    logic            src_en;
    logic            dst_en;
    logic            push;
    logic            pop;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] rd_ptr_d;
    T                mem_q [2];

    isochronous_ce_gen #(
        .Ratio (Ratio)
    ) u_ce_gen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .sync_i    (sync_i),
        .slow_en_o (slow_en)
    );

    assign slow_en_o = slow_en;

    // Only the slow side is gated; the other side handshakes every cycle.
    assign src_en = SrcSlow ? slow_en : 1'b1;
    assign dst_en = SrcSlow ? 1'b1 : slow_en;

    // All outputs come straight from registers, so no input reaches an output combinationally.
    assign src_ready_o = ((wr_ptr_q ^ rd_ptr_q) != PtrFullXor);
    assign dst_valid_o = (wr_ptr_q != rd_ptr_q);
    assign dst_data_o  = mem_q[rd_ptr_q[0]];

    // Push is judged against the registered full flag, so a same-cycle pop cannot make room.
    assign push = src_valid_i & src_ready_o & src_en;
    assign pop  = dst_valid_o & dst_ready_i & dst_en;

    // Pointer advance on accepted handshakes, 2-bit wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage: write the slot selected by the low write-pointer bit on push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q[0]] <= src_data_i;
        end
    end

    // Source must hold an offered beat unchanged until it is taken.
    a_src_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (src_valid_i && !push) |=> (src_valid_i && $stable(src_data_i)));

    // An offered output beat stays put until it is popped.
    a_dst_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dst_valid_o && !pop) |=> (dst_valid_o && $stable(dst_data_o)));

endmodule

// File: tb/tb_isochronous_ce_spill_register.sv
// tb/tb_isochronous_ce_spill_register.sv - self-checking bench for isochronous_ce_spill_register
module tb_isochronous_ce_spill_register;

    localparam int N = 4;

    function automatic int rat_of(input int g);
        case (g)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    localparam bit [N-1:0] SS_V = 4'b0100;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   sv, dr, sy, sr, dv, se;
    logic [7:0]     sd [N];
    logic [7:0]     dd [N];

    int             total = 0;
    int             bad   = 0;

    // Reference model: occupancy list (front at index 0) and slow-period phase per instance.
    logic [7:0]     mbuf [N][2];
    int             mcnt [N];
    int             ph   [N];
    bit             last_push [N];
    logic [7:0]     seq  [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        isochronous_ce_spill_register #(
            .T       (logic [7:0]),
            .Ratio   (rat_of(g)),
            .SrcSlow (SS_V[g])
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .sync_i      (sy[g]),
            .slow_en_o   (se[g]),
            .src_valid_i (sv[g]),
            .src_ready_o (sr[g]),
            .src_data_i  (sd[g]),
            .dst_valid_o (dv[g]),
            .dst_ready_i (dr[g]),
            .dst_data_o  (dd[g])
        );
    end

    task automatic chk(input string nm, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mcnt[i] = 0;
            ph[i] = 0;
            last_push[i] = 1'b0;
        end
    endtask

    task automatic reset_chk();
        for (int i = 0; i < N; i++) begin
            chk("rst_src_ready", i, int'(sr[i]), 1);
            chk("rst_dst_valid", i, int'(dv[i]), 0);
            chk("rst_dst_data", i, int'(dd[i]), 0);
            chk("rst_slow_en", i, int'(se[i]), (rat_of(i) == 1) ? 1 : 0);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            chk("slow_en", i, int'(se[i]), (ph[i] == rat_of(i) - 1) ? 1 : 0);
            chk("src_ready", i, int'(sr[i]), (mcnt[i] < 2) ? 1 : 0);
            chk("dst_valid", i, int'(dv[i]), (mcnt[i] > 0) ? 1 : 0);
            if (mcnt[i] > 0) chk("dst_data", i, int'(dd[i]), int'(mbuf[i][0]));
        end
    endtask

    // Apply current inputs across one rising edge, advance the model, compare at the falling edge.
    task automatic step();
        for (int i = 0; i < N; i++) begin
            bit en, s_en, d_en, pu, po;
            en   = (ph[i] == rat_of(i) - 1);
            s_en = SS_V[i] ? en : 1'b1;
            d_en = SS_V[i] ? 1'b1 : en;
            pu   = sv[i] && (mcnt[i] < 2) && s_en;
            po   = dr[i] && (mcnt[i] > 0) && d_en;
            if (po) begin
                mbuf[i][0] = mbuf[i][1];
                mcnt[i]--;
            end
            if (pu) begin
                mbuf[i][mcnt[i]] = sd[i];
                mcnt[i]++;
            end
            last_push[i] = pu;
            ph[i] = sy[i] ? 0 : (ph[i] + 1) % rat_of(i);
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Random source/sink; an offered beat is held until the model says it was taken.
    task automatic drive(input int vp, input int rp, input bit rsync);
        for (int i = 0; i < N; i++) begin
            if (!(sv[i] && !last_push[i])) begin
                sv[i] = ($urandom_range(99) < vp);
                if (sv[i]) begin
                    sd[i] = seq[i];
                    seq[i] = seq[i] + 8'd1;
                end
            end
            dr[i] = ($urandom_range(99) < rp);
            sy[i] = rsync && ($urandom_range(39) == 0);
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       e_rdy;
        logic       e_val;
        logic       cd;
        logic [7:0] e_dat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        bit en;
        bit seen;

        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[3]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[4]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44};
        tbl[8]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55};
        tbl[9]  = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 8'h66};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h66};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

        rst_n = 1'b0;
        sv = '0; dr = '0; sy = '0;
        for (int i = 0; i < N; i++) begin
            sd[i] = 8'h00;
            seq[i] = 8'h01;
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_chk();
        rst_n = 1'b1;

        // Ratio=1 instance: plain 2-deep spill register vectors.
        for (int k = 0; k < 12; k++) begin
            sv[3] = tbl[k].v;
            sd[3] = tbl[k].d;
            dr[3] = tbl[k].r;
            step();
            chk("tbl_src_ready", k, int'(sr[3]), int'(tbl[k].e_rdy));
            chk("tbl_dst_valid", k, int'(dv[3]), int'(tbl[k].e_val));
            if (tbl[k].cd) chk("tbl_dst_data", k, int'(dd[3]), int'(tbl[k].e_dat));
        end
        sv[3] = 1'b0; dr[3] = 1'b0;

        // Ratio=3 dst-slow: fill, then pop while a third beat waits.
        sv[1] = 1'b1; sd[1] = 8'h0A; dr[1] = 1'b0;
        step();
        chk("full_after1_valid", 1, int'(dv[1]), 1);
        sd[1] = 8'h0B;
        step();
        chk("full_after2_ready", 1, int'(sr[1]), 0);
        sd[1] = 8'h0C; dr[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            en = se[1];
            step();
            seen = en;
        end
        chk("full_pop_seen", 1, int'(seen), 1);
        chk("full_pop_front", 1, int'(dd[1]), 8'h0B);
        chk("full_pop_ready", 1, int'(sr[1]), 1);
        step();
        chk("full_c_taken", 1, int'(sr[1]), 0);
        chk("full_c_front", 1, int'(dd[1]), 8'h0B);
        sv[1] = 1'b0; dr[1] = 1'b0;

        // Ratio=4 src-slow: load one beat, then sync at cnt=1.
        sv[2] = 1'b1; sd[2] = 8'h5A; dr[2] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            en = se[2];
            step();
            seen = en;
        end
        chk("sync_load_seen", 2, int'(seen), 1);
        sv[2] = 1'b0;
        step();
        chk("sync_pre_en", 2, int'(se[2]), 0);
        sy[2] = 1'b1;
        step();
        sy[2] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("sync_phase", k, int'(se[2]), (k == 4) ? 1 : 0);
            if (k < 4) step();
        end
        chk("sync_keep_valid", 2, int'(dv[2]), 1);
        chk("sync_keep_data", 2, int'(dd[2]), 8'h5A);

        // Full-rate streaming on every instance, then random traffic with occasional syncs.
        for (int c = 0; c < 60; c++) begin
            drive(100, 100, 1'b0);
            step();
        end
        for (int c = 0; c < 400; c++) begin
            drive(70, 50, 1'b1);
            step();
        end
        for (int c = 0; c < 12; c++) begin
            drive(0, 100, 1'b0);
            step();
        end

        // Reset while the Ratio=2 instance holds two beats.
        sv = '0; dr = '0; sy = '0;
        sv[0] = 1'b1; sd[0] = 8'hA1;
        step();
        sd[0] = 8'hA2;
        step();
        sv[0] = 1'b0;
        chk("mid_full", 0, int'(sr[0]), 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_ready", 0, int'(sr[0]), 1);
        chk("mid_rst_valid", 0, int'(dv[0]), 0);
        chk("mid_rst_slow_en", 0, int'(se[0]), 0);
        @(posedge clk);
        @(negedge clk);
        reset_chk();
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            drive(60, 60, 1'b0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
